regfile_param: RTL



---
 rtl/regfile_if.sv | 27 ++
 rtl/regfile_param.sv | 77 +++++++
 2 files changed

// File: rtl/regfile_if.sv
// regfile_if: decode/writeback-side bus of the register file (clear request, write port, two read ports).
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              busy;

    modport master (
        output clr, we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  clr, we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: 1W/2R register file with registered reads, optional bypass and zero entry, and a self-timed clear sweep.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata1, r_rdata2;
    logic [DATA_W-1:0] w_rdata1_nxt, w_rdata2_nxt;
    logic              w_busy, w_wr_en;

    assign w_busy  = (r_state == S_CLEAR);
    assign w_wr_en = !w_busy && bus.we && !(ZERO_REG && bus.waddr == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        if (w_busy) begin
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            w_state_nxt   = (&r_clr_ptr) ? S_IDLE : S_CLEAR;
        end else if (bus.clr) begin
            w_state_nxt   = S_CLEAR;
            w_clr_ptr_nxt = '0;
        end
    end

    // Priority per port: busy, hold, zero entry, bypass, array (pre-edge contents).
    assign w_rdata1_nxt = w_busy ? '0 :
                          !bus.re1 ? r_rdata1 :
                          (ZERO_REG && bus.raddr1 == '0) ? '0 :
                          (BYPASS && bus.we && bus.raddr1 == bus.waddr) ? bus.wdata :
                          r_mem[bus.raddr1];
    assign w_rdata2_nxt = w_busy ? '0 :
                          !bus.re2 ? r_rdata2 :
                          (ZERO_REG && bus.raddr2 == '0) ? '0 :
                          (BYPASS && bus.we && bus.raddr2 == bus.waddr) ? bus.wdata :
                          r_mem[bus.raddr2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_rdata1  <= '0;
            r_rdata2  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_rdata1  <= w_rdata1_nxt;
            r_rdata2  <= w_rdata2_nxt;
        end
    end

    // Storage has no per-entry reset so it can map onto RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_busy)
                r_mem[r_clr_ptr] <= '0;
            else if (w_wr_en)
                r_mem[bus.waddr] <= bus.wdata;
        end
    end

    assign bus.rdata1 = r_rdata1;
    assign bus.rdata2 = r_rdata2;
    assign bus.busy   = w_busy;
endmodule
